// File: rtl/squeeze_pkg.sv
`default_nettype none
// ============================================================================
// squeeze_pkg : fire-layer geometry table, word-total helper, buffer enums
// Rev 1.0
// ============================================================================
package squeeze_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 16;
    localparam int WORD_W = LANES * LANE_W;

    typedef struct packed {
        logic [9:0] inputchannel;
        logic [6:0] inputsize;
        logic [6:0] filtersize;
    } fire_cfg_t;

    localparam fire_cfg_t FIRE_TABLE [8] = '{
        '{10'd96,  7'd55, 7'd16},
        '{10'd128, 7'd55, 7'd16},
        '{10'd128, 7'd27, 7'd32},
        '{10'd256, 7'd27, 7'd32},
        '{10'd256, 7'd13, 7'd48},
        '{10'd384, 7'd13, 7'd48},
        '{10'd384, 7'd13, 7'd64},
        '{10'd512, 7'd13, 7'd64}
    };

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_WRITING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    typedef enum logic [1:0] {
        WR_IDLE      = 2'd0,
        WR_WAIT_BANK = 2'd1,
        WR_FILL      = 2'd2
    } wr_state_e;

    // One word per pixel per group of eight filters.
    function automatic int fire_words(input logic [2:0] sel);
        fire_cfg_t cfg;
        cfg = FIRE_TABLE[sel];
        return (int'(cfg.filtersize) / LANES) * int'(cfg.inputsize) * int'(cfg.inputsize);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sqzbuf_bank.sv
`default_nettype none
// ============================================================================
// sqzbuf_bank : one ping-pong bank, simple dual-port RAM with registered read
// Rev 1.0
// ============================================================================
module sqzbuf_bank
    import squeeze_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int AW    = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/squeeze_out_buffer.sv
`default_nettype none
// ============================================================================
// squeeze_out_buffer : ping-pong capture of squeeze beats, random-access reader
// Optional macro SQZBUF_RELU_EN clamps negative lanes to zero on write.  Rev 1.0
// ============================================================================
module squeeze_out_buffer
    import squeeze_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int AW    = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        firesel,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              layer_done,
    output logic              overflow,
    output logic              rd_bank_valid,
    output logic [AW:0]       rd_words,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              rd_release
);

    localparam int CW = AW + 1;

    wr_state_e         state_q, state_d;
    bank_state_e       bank_st_q [2];
    bank_state_e       bank_st_d [2];
    logic [AW:0]       bank_cnt_q [2];
    logic [AW:0]       bank_cnt_d [2];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [AW:0]       total_q, total_d;
    logic [AW:0]       wr_cnt_q, wr_cnt_d;
    logic              in_ready_q, layer_done_q, overflow_q;
    logic              rd_bank_valid_q, rd_data_valid_q, rd_src_q;
    logic [AW:0]       rd_words_q;
    logic              w_beat, w_last, w_rd_acc;
    logic [WORD_W-1:0] w_wr_data;
    logic [WORD_W-1:0] w_bank_rdata [2];

    // A restart pulse takes priority over a coincident beat.
    assign w_beat   = in_valid & in_ready_q & ~start;
    assign w_last   = w_beat & (wr_cnt_q == (total_q - CW'(1)));
    assign w_rd_acc = rd_en & rd_bank_valid_q;

`ifdef SQZBUF_RELU_EN
    for (genvar l = 0; l < LANES; l++) begin : g_relu
        assign w_wr_data[l*LANE_W +: LANE_W] =
            in_data[l*LANE_W + LANE_W - 1] ? '0 : in_data[l*LANE_W +: LANE_W];
    end
`else
    assign w_wr_data = in_data;
`endif

    always_comb begin
        state_d    = state_q;
        bank_st_d  = bank_st_q;
        bank_cnt_d = bank_cnt_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        total_d    = total_q;
        wr_cnt_d   = wr_cnt_q;

        unique case (state_q)
            WR_IDLE: begin
                if (start) begin
                    total_d  = CW'(fire_words(firesel));
                    wr_cnt_d = '0;
                    state_d  = WR_WAIT_BANK;
                    if (bank_st_q[wr_sel_q] == BANK_FREE) begin
                        state_d             = WR_FILL;
                        bank_st_d[wr_sel_q] = BANK_WRITING;
                    end
                end
            end
            WR_WAIT_BANK: begin
                if (start) begin
                    total_d  = CW'(fire_words(firesel));
                    wr_cnt_d = '0;
                end
                if (bank_st_q[wr_sel_q] == BANK_FREE) begin
                    state_d             = WR_FILL;
                    bank_st_d[wr_sel_q] = BANK_WRITING;
                end
            end
            WR_FILL: begin
                if (start) begin
                    total_d  = CW'(fire_words(firesel));
                    wr_cnt_d = '0;
                end else if (w_beat) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (w_last) begin
                        bank_st_d[wr_sel_q]  = BANK_FULL;
                        bank_cnt_d[wr_sel_q] = total_q;
                        wr_sel_d             = ~wr_sel_q;
                        state_d              = WR_IDLE;
                    end
                end
            end
            default: state_d = WR_IDLE;
        endcase

        // The reader only ever holds a FULL bank, so it never races the writer.
        if (rd_release && rd_bank_valid_q) begin
            bank_st_d[rd_sel_q] = BANK_FREE;
            rd_sel_d            = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= WR_IDLE;
            bank_st_q       <= '{BANK_FREE, BANK_FREE};
            bank_cnt_q      <= '{default: '0};
            wr_sel_q        <= 1'b0;
            rd_sel_q        <= 1'b0;
            total_q         <= '0;
            wr_cnt_q        <= '0;
            in_ready_q      <= 1'b0;
            layer_done_q    <= 1'b0;
            overflow_q      <= 1'b0;
            rd_bank_valid_q <= 1'b0;
            rd_words_q      <= '0;
            rd_data_valid_q <= 1'b0;
            rd_src_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            bank_st_q       <= bank_st_d;
            bank_cnt_q      <= bank_cnt_d;
            wr_sel_q        <= wr_sel_d;
            rd_sel_q        <= rd_sel_d;
            total_q         <= total_d;
            wr_cnt_q        <= wr_cnt_d;
            in_ready_q      <= (state_q == WR_FILL) && (state_d == WR_FILL);
            layer_done_q    <= w_last;
            overflow_q      <= overflow_q | (in_valid & ~in_ready_q);
            rd_bank_valid_q <= (bank_st_d[rd_sel_d] == BANK_FULL);
            rd_words_q      <= (bank_st_d[rd_sel_d] == BANK_FULL) ? bank_cnt_d[rd_sel_d] : '0;
            rd_data_valid_q <= w_rd_acc;
            if (w_rd_acc) begin
                rd_src_q <= rd_sel_q;
            end
        end
    end

    // rd_src_q only moves on an accepted read, so rd_data holds between reads.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        sqzbuf_bank #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (w_beat && (wr_sel_q == 1'(b))),
            .wr_addr_i (wr_cnt_q[AW-1:0]),
            .wr_data_i (w_wr_data),
            .rd_en_i   (w_rd_acc && (rd_sel_q == 1'(b))),
            .rd_addr_i (rd_addr),
            .rd_data_o (w_bank_rdata[b])
        );
    end

    assign in_ready      = in_ready_q;
    assign layer_done    = layer_done_q;
    assign overflow      = overflow_q;
    assign rd_bank_valid = rd_bank_valid_q;
    assign rd_words      = rd_words_q;
    assign rd_data       = rd_src_q ? w_bank_rdata[1] : w_bank_rdata[0];
    assign rd_data_valid = rd_data_valid_q;

endmodule
`default_nettype wire
